// File: rtl/aliniere_adunare.sv
// Alignment and add/subtract stage of a single-precision adder.
// Unpacks two operands, aligns the smaller mantissa one bit per cycle with a
// sticky bit, then adds or subtracts magnitudes for a later normalization stage.
module aliniere_adunare (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [27:0] sum_mag,
    output logic        sign,
    output logic [7:0]  exp_c,
    output logic        zero,
    output logic        special
);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        SHIFT,
        ADD,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_op;
    logic [26:0] r_large;
    logic [26:0] r_small;
    logic [4:0]  r_cnt;
    logic        r_largeSign;
    logic [27:0] r_sumMag;
    logic        r_sign;
    logic [7:0]  r_expC;
    logic        r_zero;
    logic        r_special;

    logic [7:0]  w_expA;
    logic [7:0]  w_expB;
    logic [26:0] w_mantA;
    logic [26:0] w_mantB;
    logic        w_aLarge;
    logic [7:0]  w_expDiff;
    logic [4:0]  w_shiftAmt;
    logic        w_signB;
    logic        w_effSub;
    logic        w_special;
    logic [26:0] w_shifted;
    logic [27:0] w_sum;

    // Denormals (exponent 0) behave as exponent 1 without the hidden bit.
    assign w_expA     = (r_a[30:23] == 8'd0) ? 8'd1 : r_a[30:23];
    assign w_expB     = (r_b[30:23] == 8'd0) ? 8'd1 : r_b[30:23];
    assign w_mantA    = {(r_a[30:23] != 8'd0), r_a[22:0], 3'b000};
    assign w_mantB    = {(r_b[30:23] != 8'd0), r_b[22:0], 3'b000};

    // Exponent sits above the mantissa, so this also orders by exponent first.
    assign w_aLarge   = ({w_expA, w_mantA} >= {w_expB, w_mantB});
    assign w_expDiff  = w_aLarge ? (w_expA - w_expB) : (w_expB - w_expA);
    assign w_shiftAmt = (w_expDiff > 8'd27) ? 5'd27 : w_expDiff[4:0];

    assign w_signB    = r_b[31] ^ r_op;
    assign w_effSub   = r_a[31] ^ w_signB;
    assign w_special  = (&r_a[30:23]) | (&r_b[30:23]);

    // One-bit right shift; the bit falling off bit 0 stays folded into bit 0.
    assign w_shifted  = {1'b0, r_small[26:2], r_small[1] | r_small[0]};
    assign w_sum      = w_effSub ? ({1'b0, r_large} - {1'b0, r_small})
                                 : ({1'b0, r_large} + {1'b0, r_small});

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign sum_mag    = r_sumMag;
    assign sign       = r_sign;
    assign exp_c      = r_expC;
    assign zero       = r_zero;
    assign special    = r_special;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: d shift cycles only when the exponents differ.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = COMPARE;
            COMPARE: w_next = (w_shiftAmt != 5'd0) ? SHIFT : ADD;
            SHIFT:   if (r_cnt == 5'd1) w_next = ADD;
            ADD:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture, order operands, align, then add/subtract into outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_op        <= 1'b0;
            r_large     <= 27'd0;
            r_small     <= 27'd0;
            r_cnt       <= 5'd0;
            r_largeSign <= 1'b0;
            r_sumMag    <= 28'd0;
            r_sign      <= 1'b0;
            r_expC      <= 8'd0;
            r_zero      <= 1'b0;
            r_special   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a  <= a;
                        r_b  <= b;
                        r_op <= op;
                    end
                end
                COMPARE: begin
                    r_large     <= w_aLarge ? w_mantA : w_mantB;
                    r_small     <= w_aLarge ? w_mantB : w_mantA;
                    r_expC      <= w_aLarge ? w_expA : w_expB;
                    r_largeSign <= w_aLarge ? r_a[31] : w_signB;
                    r_cnt       <= w_shiftAmt;
                end
                SHIFT: begin
                    r_small <= w_shifted;
                    r_cnt   <= r_cnt - 5'd1;
                end
                ADD: begin
                    r_special <= w_special;
                    if (w_special) begin
                        r_sumMag <= 28'd0;
                        r_zero   <= 1'b0;
                        r_sign   <= 1'b0;
                    end else begin
                        r_sumMag <= w_sum;
                        r_zero   <= (w_sum == 28'd0);
                        r_sign   <= (w_sum == 28'd0) ? 1'b0 : r_largeSign;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aliniere_adunare.sv
// Self-checking bench for aliniere_adunare: directed corner cases plus
// randomized operand pairs checked against an arithmetic reference model.
module tb_aliniere_adunare;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [27:0] sum_mag;
    logic        sign;
    logic [7:0]  exp_c;
    logic        zero;
    logic        special;

    typedef struct {
        logic [27:0] sum;
        logic        sgn;
        logic [7:0]  ex;
        logic        zr;
        logic        sp;
        int          lat;
        int          accCyc;
    } expT;

    expT expQ[$];
    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;
    int  readyMode = 0;
    bit  seenValid = 1'b0;

    aliniere_adunare dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .sum_mag(sum_mag), .sign(sign), .exp_c(exp_c), .zero(zero),
        .special(special)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: align with the exact shift amount, sticky = OR of all lost bits.
    function automatic expT model(input logic [31:0] fa, input logic [31:0] fb, input logic fop);
        expT    r;
        longint ma, mb, ml, ms, sh, s;
        int     ea, eb, el, d;
        bit     sa, sb, aL;
        ea = (fa[30:23] == 8'd0) ? 1 : int'(fa[30:23]);
        eb = (fb[30:23] == 8'd0) ? 1 : int'(fb[30:23]);
        ma = (longint'(fa[22:0]) + ((fa[30:23] != 8'd0) ? (longint'(1) << 23) : 64'sd0)) * 8;
        mb = (longint'(fb[22:0]) + ((fb[30:23] != 8'd0) ? (longint'(1) << 23) : 64'sd0)) * 8;
        sa = fa[31];
        sb = fb[31] ^ fop;
        aL = (ea > eb) || ((ea == eb) && (ma >= mb));
        d  = aL ? ea - eb : eb - ea;
        if (d > 27) d = 27;
        ml = aL ? ma : mb;
        ms = aL ? mb : ma;
        el = aL ? ea : eb;
        sh = ms >> d;
        if ((ms & ((longint'(1) << d) - 1)) != 0) sh = sh | 1;
        s = (sa != sb) ? ml - sh : ml + sh;
        r.sp = (fa[30:23] == 8'hFF) || (fb[30:23] == 8'hFF);
        if (r.sp) s = 0;
        r.sum    = s[27:0];
        r.zr     = !r.sp && (s == 0);
        r.sgn    = (s == 0) ? 1'b0 : (aL ? sa : sb);
        r.ex     = el[7:0];
        r.lat    = d + 2;
        r.accCyc = 0;
        return r;
    endfunction

    // Present one operand pair as soon as the block is idle; called at posedge+1.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic top);
        expT e;
        int  guard = 0;
        while (in_ready !== 1'b1) begin
            if (guard >= 300) begin
                checkOutput("in_ready timeout", 32'(in_ready), 32'd1);
                return;
            end
            @(posedge clk); #1;
            guard++;
        end
        e = model(ta, tb, top);
        e.accCyc = cyc + 1;
        expQ.push_back(e);
        a = ta;
        b = tb;
        op = top;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drainQueue();
        int guard = 0;
        while (expQ.size() != 0) begin
            if (guard >= 300) begin
                checkOutput("drain timeout", 32'(expQ.size()), 32'd0);
                expQ.delete();
                return;
            end
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic pinModel(input string name, input logic [31:0] ta, input logic [31:0] tb,
                            input logic top, input logic [27:0] s, input logic sg,
                            input logic [7:0] ex, input logic zr, input int lat);
        expT e;
        e = model(ta, tb, top);
        checkOutput({name, " model sum"}, 32'(e.sum), 32'(s));
        checkOutput({name, " model sign"}, 32'(e.sgn), 32'(sg));
        checkOutput({name, " model exp"}, 32'(e.ex), 32'(ex));
        checkOutput({name, " model zero"}, 32'(e.zr), 32'(zr));
        checkOutput({name, " model latency"}, 32'(e.lat), 32'(lat));
    endtask

    // Result checker: every cycle out_valid is high, outputs must equal the model.
    always @(negedge clk) begin
        expT e;
        if (rst_n && out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = expQ[0];
                checkOutput("sum_mag", 32'(sum_mag), 32'(e.sum));
                checkOutput("sign", 32'(sign), 32'(e.sgn));
                checkOutput("exp_c", 32'(exp_c), 32'(e.ex));
                checkOutput("zero", 32'(zero), 32'(e.zr));
                checkOutput("special", 32'(special), 32'(e.sp));
                checkOutput("in_ready in DONE", 32'(in_ready), 32'd0);
                if (!seenValid) begin
                    checkOutput("latency", 32'(cyc - e.accCyc), 32'(e.lat));
                    seenValid = 1'b1;
                end
                if (out_ready) begin
                    void'(expQ.pop_front());
                    seenValid = 1'b0;
                end
            end
        end
    end

    // Downstream ready: random, held low, or held high
    initial begin
        forever begin
            @(posedge clk); #1;
            case (readyMode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        int          ea, eb, sel, guard;
        logic [31:0] ra, rb;

        readyMode = 2;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset sum_mag", 32'(sum_mag), 32'd0);
        checkOutput("reset exp_c", 32'(exp_c), 32'd0);
        checkOutput("reset sign/zero/special", {29'd0, sign, zero, special}, 32'd0);
        rst_n = 1'b1;

        pinModel("1+1", 32'h3F800000, 32'h3F800000, 1'b0, 28'h8000000, 1'b0, 8'd127, 1'b0, 2);
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0);
        pinModel("1-1", 32'h3F800000, 32'h3F800000, 1'b1, 28'h0, 1'b0, 8'd127, 1'b1, 2);
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b1);
        pinModel("3-1", 32'h40400000, 32'h3F800000, 1'b1, 28'h4000000, 1'b0, 8'd128, 1'b0, 3);
        applyStimulus(32'h40400000, 32'h3F800000, 1'b1);
        pinModel("1-3", 32'h3F800000, 32'h40400000, 1'b1, 28'h4000000, 1'b1, 8'd128, 1'b0, 3);
        applyStimulus(32'h3F800000, 32'h40400000, 1'b1);
        pinModel("1+2^-30", 32'h3F800000, 32'h30800000, 1'b0, 28'h4000001, 1'b0, 8'd127, 1'b0, 29);
        applyStimulus(32'h3F800000, 32'h30800000, 1'b0);
        drainQueue();

        // Backpressure: hold result for 5 cycles while in_valid pulses
        readyMode = 1;
        @(posedge clk); #1;
        applyStimulus(32'h40400000, 32'h3F800000, 1'b0);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("backpressure reached DONE", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a = 32'h42000000;
            b = 32'h41000000;
            in_valid = i[0];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("held out_valid", 32'(out_valid), 32'd1);
        readyMode = 2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("IDLE after release", 32'(in_ready), 32'd1);
        checkOutput("no stray capture", 32'(expQ.size()), 32'd0);

        // Reset in the middle of a long alignment
        applyStimulus(32'h3F800000, 32'h30800000, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midshift reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midshift reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("midshift reset exp_c", 32'(exp_c), 32'd0);
        checkOutput("midshift reset sum_mag", 32'(sum_mag), 32'd0);
        checkOutput("midshift reset flags", {29'd0, sign, zero, special}, 32'd0);
        expQ.delete();
        seenValid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(32'h40400000, 32'h3F800000, 1'b1);
        drainQueue();

        // Randomized operand pairs
        readyMode = 0;
        for (int i = 0; i < 150; i++) begin
            ea = int'($urandom_range(1, 254));
            eb = ea + int'($urandom_range(0, 60)) - 30;
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) ea = 0;
            if (sel == 1) eb = 255;
            if (sel == 2) ea = 255;
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
            if (sel == 3) rb = {1'($urandom), ra[30:0]};
            applyStimulus(ra, rb, 1'($urandom));
        end
        drainQueue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
